ad936x_mc_data_interface: RTL and testbench

AD936X_MC_DATA_INTERFACE -- requirements
Module: ad936x_mc_data_interface

---
 rtl/ad936x_mc_data_interface.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ad936x_mc_data_interface.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad936x_mc_data_interface.sv
//==============================================================================
//  Module      : ad936x_mc_data_interface
//  Description : Multi-channel AD936x single-port data interface. Oversamples
//                the chip's DATA_CLK, RX_FRAME and RX data with the system
//                clock, assembles RX words into frames that are handed to the
//                baseband through a first-word-fall-through FIFO, and
//                serialises baseband TX frames onto the chip's TX word bus.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
//  Parameters
//    WIDTH         bits per I or Q word
//    NUM_CHANNELS  1 (1R1T) or 2 (2R2T); frame length F = 2*NUM_CHANNELS words
//    FIFO_DEPTH    RX frame FIFO depth, power of 2, >= 2
//  Ports
//    clk, rst                    system clock (>= 4x data_clk), sync reset
//    bbp_rx_data/valid/ready     RX frame stream, word k at [k*WIDTH +: WIDTH]
//    bbp_tx_data/valid/ready     TX frame stream, same packing
//    ad936x_rx_data/rx_frame     asynchronous RX inputs from the chip
//    ad936x_data_clk             asynchronous sample clock from the chip
//    ad936x_data_clk_fb          synchronised data clock echoed to the chip
//    ad936x_tx_data/tx_frame     TX word bus to the chip
//    rx_overflow, tx_underrun    single-cycle event pulses
//    stats_clear                 clears the event counters
//    rx_overflow_count           saturating overflow event counter
//    tx_underrun_count           saturating underrun event counter
//  Build option
//    AD936X_MC_STATS_EN          when defined, the event counters are built;
//                                otherwise the count ports are tied to 0.
//==============================================================================
`default_nettype none

module ad936x_mc_data_interface #(
    parameter int WIDTH        = 12,
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [2*NUM_CHANNELS*WIDTH-1:0]     bbp_rx_data,
    output logic                                bbp_rx_valid,
    input  logic                                bbp_rx_ready,
    input  logic [2*NUM_CHANNELS*WIDTH-1:0]     bbp_tx_data,
    input  logic                                bbp_tx_valid,
    output logic                                bbp_tx_ready,
    input  logic [WIDTH-1:0]                    ad936x_rx_data,
    input  logic                                ad936x_rx_frame,
    input  logic                                ad936x_data_clk,
    output logic                                ad936x_data_clk_fb,
    output logic [WIDTH-1:0]                    ad936x_tx_data,
    output logic                                ad936x_tx_frame,
    output logic                                rx_overflow,
    output logic                                tx_underrun,
    input  logic                                stats_clear,
    output logic [15:0]                         rx_overflow_count,
    output logic [15:0]                         tx_underrun_count
);

    localparam int FRAME_WORDS = 2 * NUM_CHANNELS;
    localparam int FRAME_BITS  = FRAME_WORDS * WIDTH;
    localparam int IDX_W       = $clog2(FRAME_WORDS);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0] NUM_CH_IDX = IDX_W'(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE    = (PTR_W + 1)'(1);

    //--------------------------------------------------------------------------
    // Synchronisers. data_clk uses two flops plus a history flop for edge
    // detection; data and frame get a third flop so the captured word is the
    // one that was stable before the data_clk rise seen by the detector.
    //--------------------------------------------------------------------------
    logic             r_dclk_s1, r_dclk_s2, r_dclk_s3;
    logic             r_frame_s1, r_frame_s2, r_frame_s3;
    logic [WIDTH-1:0] r_data_s1, r_data_s2, r_data_s3;
    logic             w_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dclk_s1  <= 1'b0;
            r_dclk_s2  <= 1'b0;
            r_dclk_s3  <= 1'b0;
            r_frame_s1 <= 1'b0;
            r_frame_s2 <= 1'b0;
            r_frame_s3 <= 1'b0;
            r_data_s1  <= '0;
            r_data_s2  <= '0;
            r_data_s3  <= '0;
        end else begin
            r_dclk_s1  <= ad936x_data_clk;
            r_dclk_s2  <= r_dclk_s1;
            r_dclk_s3  <= r_dclk_s2;
            r_frame_s1 <= ad936x_rx_frame;
            r_frame_s2 <= r_frame_s1;
            r_frame_s3 <= r_frame_s2;
            r_data_s1  <= ad936x_rx_data;
            r_data_s2  <= r_data_s1;
            r_data_s3  <= r_data_s2;
        end
    end

    assign w_edge             = r_dclk_s2 & ~r_dclk_s3;
    assign ad936x_data_clk_fb = r_dclk_s2;

    //--------------------------------------------------------------------------
    // RX frame alignment and word assembly
    //--------------------------------------------------------------------------
    typedef enum logic [0:0] {
        RX_UNALIGNED = 1'b0,
        RX_ALIGNED   = 1'b1
    } rx_state_t;

    rx_state_t            r_rx_state, w_rx_state_next;
    logic                 r_prev_frame;
    logic [IDX_W-1:0]     r_rx_idx, w_rx_idx_next;
    logic [IDX_W-1:0]     w_rx_wr_idx;
    logic                 w_rx_store;
    logic                 w_push;
    logic [FRAME_BITS-1:0] r_rx_frame;
    logic [FRAME_BITS-1:0] w_push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= RX_UNALIGNED;
            r_rx_idx     <= '0;
            r_prev_frame <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_idx   <= w_rx_idx_next;
            if (w_edge) begin
                r_prev_frame <= r_frame_s3;
            end
        end
    end

    // A frame rise (high now, low at the previous edge) restarts the frame at
    // word 0; until the first rise every captured word is thrown away.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_idx_next   = r_rx_idx;
        w_rx_store      = 1'b0;
        w_rx_wr_idx     = r_rx_idx;
        if (w_edge) begin
            if (r_frame_s3 && !r_prev_frame) begin
                w_rx_state_next = RX_ALIGNED;
                w_rx_store      = 1'b1;
                w_rx_wr_idx     = '0;
            end else if (r_rx_state == RX_ALIGNED) begin
                w_rx_store = 1'b1;
            end
            if (w_rx_store) begin
                w_rx_idx_next = (w_rx_wr_idx == LAST_IDX) ? '0 : w_rx_wr_idx + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_frame <= '0;
        end else begin
            for (int k = 0; k < FRAME_WORDS; k++) begin
                if (w_rx_store && (w_rx_wr_idx == IDX_W'(k))) begin
                    r_rx_frame[k*WIDTH +: WIDTH] <= r_data_s3;
                end
            end
        end
    end

    // The last word bypasses the assembly register so the frame is pushed in
    // the same clk that word is captured.
    assign w_push      = w_rx_store && (w_rx_wr_idx == LAST_IDX);
    assign w_push_data = {r_data_s3, r_rx_frame[FRAME_BITS-WIDTH-1:0]};

    //--------------------------------------------------------------------------
    // RX frame FIFO (first-word-fall-through)
    //--------------------------------------------------------------------------
    logic [FRAME_BITS-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
    logic                  w_empty, w_full, w_pop, w_fifo_wr;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop     = bbp_rx_valid && bbp_rx_ready;
    // A pop in the same clk frees the slot, so a push while full is accepted.
    assign w_fifo_wr = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            rx_overflow <= w_push && w_full && !w_pop;
        end
    end

    // Storage is not reset, so the data port is forced to 0 while empty.
    assign bbp_rx_valid = !w_empty;
    assign bbp_rx_data  = w_empty ? '0 : r_fifo_mem[r_rd_ptr[PTR_W-1:0]];

    //--------------------------------------------------------------------------
    // TX serialiser
    //--------------------------------------------------------------------------
    logic [IDX_W-1:0]      r_tx_idx;
    logic [FRAME_BITS-1:0] r_tx_frame;
    logic [FRAME_BITS-1:0] w_tx_load;
    logic [WIDTH-1:0]      w_tx_word;

    assign bbp_tx_ready = w_edge && (r_tx_idx == '0);

    // On the frame-start edge the freshly accepted frame (or zeros) is used
    // directly, so word 0 goes out on the same edge it is latched.
    assign w_tx_load = bbp_tx_ready ? (bbp_tx_valid ? bbp_tx_data : '0) : r_tx_frame;

    always_comb begin
        w_tx_word = '0;
        for (int k = 0; k < FRAME_WORDS; k++) begin
            if (r_tx_idx == IDX_W'(k)) begin
                w_tx_word = w_tx_load[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_idx        <= '0;
            r_tx_frame      <= '0;
            ad936x_tx_data  <= '0;
            ad936x_tx_frame <= 1'b0;
            tx_underrun     <= 1'b0;
        end else begin
            tx_underrun <= bbp_tx_ready && !bbp_tx_valid;
            if (w_edge) begin
                r_tx_frame      <= w_tx_load;
                ad936x_tx_data  <= w_tx_word;
                ad936x_tx_frame <= (r_tx_idx < NUM_CH_IDX);
                r_tx_idx        <= (r_tx_idx == LAST_IDX) ? '0 : r_tx_idx + IDX_ONE;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Event statistics
    //--------------------------------------------------------------------------
`ifdef AD936X_MC_STATS_EN
    logic [15:0] r_ov_count, r_un_count;

    always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
            r_ov_count <= '0;
            r_un_count <= '0;
        end else begin
            if (rx_overflow && (r_ov_count != 16'hFFFF)) begin
                r_ov_count <= r_ov_count + 16'd1;
            end
            if (tx_underrun && (r_un_count != 16'hFFFF)) begin
                r_un_count <= r_un_count + 16'd1;
            end
        end
    end

    assign rx_overflow_count = r_ov_count;
    assign tx_underrun_count = r_un_count;
`else
    logic w_unused_stats_clear;

    assign w_unused_stats_clear = stats_clear;
    assign rx_overflow_count    = '0;
    assign tx_underrun_count    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad936x_mc_data_interface.sv
//==============================================================================
//  Module      : tb_ad936x_mc_data_interface
//  Description : Directed self-checking bench for ad936x_mc_data_interface.
//                Drives a 2R2T instance and a 1R1T instance from one clock.
//  Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ad936x_mc_data_interface;

`ifdef AD936X_MC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 2R2T instance
    logic [47:0] rx_data2, tx_bus2;
    logic        rx_valid2, rx_ready2, tx_valid2, tx_ready2;
    logic [11:0] c_rx2, c_tx2;
    logic        c_frame2, dclk2, fb2, c_txf2, ov2, un2, clr2;
    logic [15:0] ovc2, unc2;

    // 1R1T instance
    logic [23:0] rx_data1, tx_bus1;
    logic        rx_valid1, rx_ready1, tx_valid1, tx_ready1;
    logic [11:0] c_rx1, c_tx1;
    logic        c_frame1, dclk1, fb1, c_txf1, ov1, un1, clr1;
    logic [15:0] ovc1, unc1;

    ad936x_mc_data_interface #(.WIDTH(12), .NUM_CHANNELS(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .bbp_rx_data(rx_data2), .bbp_rx_valid(rx_valid2), .bbp_rx_ready(rx_ready2),
        .bbp_tx_data(tx_bus2), .bbp_tx_valid(tx_valid2), .bbp_tx_ready(tx_ready2),
        .ad936x_rx_data(c_rx2), .ad936x_rx_frame(c_frame2), .ad936x_data_clk(dclk2),
        .ad936x_data_clk_fb(fb2), .ad936x_tx_data(c_tx2), .ad936x_tx_frame(c_txf2),
        .rx_overflow(ov2), .tx_underrun(un2), .stats_clear(clr2),
        .rx_overflow_count(ovc2), .tx_underrun_count(unc2)
    );

    ad936x_mc_data_interface #(.WIDTH(12), .NUM_CHANNELS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .bbp_rx_data(rx_data1), .bbp_rx_valid(rx_valid1), .bbp_rx_ready(rx_ready1),
        .bbp_tx_data(tx_bus1), .bbp_tx_valid(tx_valid1), .bbp_tx_ready(tx_ready1),
        .ad936x_rx_data(c_rx1), .ad936x_rx_frame(c_frame1), .ad936x_data_clk(dclk1),
        .ad936x_data_clk_fb(fb1), .ad936x_tx_data(c_tx1), .ad936x_tx_frame(c_txf1),
        .rx_overflow(ov1), .tx_underrun(un1), .stats_clear(clr1),
        .rx_overflow_count(ovc1), .tx_underrun_count(unc1)
    );

    // Passive monitor: handshake beats and event pulses.
    logic [47:0] q2[$];
    logic [23:0] q1[$];
    int rdy_cnt2 = 0;
    int un_cnt2  = 0;
    int ov_cnt2  = 0;
    int ov_cnt1  = 0;

    always @(negedge clk) begin
        if (rx_valid2 && rx_ready2) q2.push_back(rx_data2);
        if (rx_valid1 && rx_ready1) q1.push_back(rx_data1);
        if (tx_ready2) rdy_cnt2++;
        if (un2)       un_cnt2++;
        if (ov2)       ov_cnt2++;
        if (ov1)       ov_cnt1++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // One data_clk period: word set up during the low half, rise, high half.
    task automatic dcycle2(input logic [11:0] d, input logic f);
        c_rx2 = d; c_frame2 = f; dclk2 = 1'b0;
        repeat (4) tick();
        dclk2 = 1'b1;
        repeat (4) tick();
    endtask

    task automatic dcycle1(input logic [11:0] d, input logic f);
        c_rx1 = d; c_frame1 = f; dclk1 = 1'b0;
        repeat (4) tick();
        dclk1 = 1'b1;
        repeat (4) tick();
    endtask

    logic [11:0] rxw  [4];
    logic        frm  [4];
    logic [11:0] txw  [4];
    logic [23:0] exp1 [4];
    int          base;

    initial begin
        rst = 1'b1;
        rx_ready2 = 1'b0; tx_valid2 = 1'b0; tx_bus2 = '0; c_rx2 = '0; c_frame2 = 1'b0;
        dclk2 = 1'b0; clr2 = 1'b0;
        rx_ready1 = 1'b0; tx_valid1 = 1'b1; tx_bus1 = '0; c_rx1 = '0; c_frame1 = 1'b0;
        dclk1 = 1'b0; clr1 = 1'b0;
        repeat (3) tick();
        sample();

        // Reset state
        check("rst_rx_valid", rx_valid2, 0);
        check("rst_rx_data",  rx_data2,  0);
        check("rst_tx_ready", tx_ready2, 0);
        check("rst_tx_data",  c_tx2,     0);
        check("rst_tx_frame", c_txf2,    0);
        check("rst_clk_fb",   fb2,       0);
        check("rst_overflow", ov2,       0);
        check("rst_underrun", un2,       0);
        check("rst_ov_count", ovc2,      0);
        check("rst_un_count", unc2,      0);
        check("rst_rx_valid1", rx_valid1, 0);
        tick();
        rst = 1'b0;
        tick();

        // RX frame + concurrent TX frame on the 2R2T instance
        rx_ready2 = 1'b1; tx_valid2 = 1'b1; tx_bus2 = 48'hDDDCCCBBBAAA;
        rxw = '{12'h111, 12'h222, 12'h333, 12'h444};
        frm = '{1'b1, 1'b1, 1'b0, 1'b0};
        txw = '{12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD};
        for (int i = 0; i < 4; i++) begin
            dcycle2(rxw[i], frm[i]);
            check($sformatf("tx1_word%0d", i),  c_tx2,  txw[i]);
            check($sformatf("tx1_frame%0d", i), c_txf2, frm[i]);
        end
        sample();
        check("rx1_beats", q2.size(), 1);
        check("rx1_data",  q2[0], 48'h444333222111);
        check("tx1_ready_cnt", rdy_cnt2, 1);
        check("tx1_no_underrun", un_cnt2, 0);

        // Second frame with new TX data
        tx_bus2 = 48'h0123456789AB;
        rxw = '{12'h555, 12'h666, 12'h777, 12'h888};
        txw = '{12'h9AB, 12'h678, 12'h345, 12'h012};
        for (int i = 0; i < 4; i++) begin
            dcycle2(rxw[i], frm[i]);
            check($sformatf("tx2_word%0d", i),  c_tx2,  txw[i]);
            check($sformatf("tx2_frame%0d", i), c_txf2, frm[i]);
        end
        sample();
        check("rx2_beats", q2.size(), 2);
        check("rx2_data",  q2[1], 48'h888777666555);
        check("tx2_ready_cnt", rdy_cnt2, 2);

        // TX underrun for three frames
        tx_valid2 = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                dcycle2(12'h0F0, frm[i]);
                check($sformatf("und_word_f%0d_w%0d", f, i), c_tx2, 0);
            end
        end
        sample();
        check("und_pulses", un_cnt2, 3);
        check("und_count",  unc2, STATS ? 16'd3 : 16'd0);
        tick();
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        sample();
        check("und_count_clr", unc2, 0);

        // RX stream started mid-frame after reset
        tx_valid2 = 1'b1;
        tick();
        dclk2 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        base = q2.size();
        dcycle2(12'hA01, 1'b0);
        dcycle2(12'hA02, 1'b0);
        dcycle2(12'hB01, 1'b1);
        dcycle2(12'hB02, 1'b1);
        dcycle2(12'hB03, 1'b0);
        dcycle2(12'hB04, 1'b0);
        sample();
        check("mid_beats", q2.size(), base + 1);
        check("mid_data",  q2[base], 48'hB04B03B02B01);

        // Reset during word 2 of an RX frame
        tick();
        tx_bus2 = 48'hFEDCBA987654;
        base = q2.size();
        dcycle2(12'hC01, 1'b1);
        dcycle2(12'hC02, 1'b1);
        c_rx2 = 12'hC03; c_frame2 = 1'b0; dclk2 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        sample();
        check("rstmid_rx_valid", rx_valid2, 0);
        check("rstmid_rx_data",  rx_data2,  0);
        check("rstmid_tx_ready", tx_ready2, 0);
        check("rstmid_tx_data",  c_tx2,     0);
        check("rstmid_tx_frame", c_txf2,    0);
        check("rstmid_clk_fb",   fb2,       0);
        tick();
        rst = 1'b0;
        tick();
        dclk2 = 1'b1;
        repeat (4) tick();
        check("rstmid_tx_first_word",  c_tx2,  12'h654);
        check("rstmid_tx_first_frame", c_txf2, 1);
        dcycle2(12'hC04, 1'b0);
        sample();
        check("rstmid_no_beat", q2.size(), base);
        tick();
        dcycle2(12'hD01, 1'b1);
        dcycle2(12'hD02, 1'b1);
        dcycle2(12'hD03, 1'b0);
        dcycle2(12'hD04, 1'b0);
        sample();
        check("rstmid_next_beats", q2.size(), base + 1);
        check("rstmid_next_data",  q2[base], 48'hD04D03D02D01);
        check("no_overflow2", ov_cnt2, 0);

        // 1R1T overflow: five frames into a four-deep FIFO with ready low
        tick();
        for (int k = 1; k <= 5; k++) begin
            dcycle1(12'(k * 256 + 1), 1'b1);
            dcycle1(12'(k * 256 + 2), 1'b0);
        end
        sample();
        check("ovf_pulses", ov_cnt1, 1);
        check("ovf_count",  ovc1, STATS ? 16'd1 : 16'd0);
        check("ovf_valid",  rx_valid1, 1);
        check("ovf_head",   rx_data1, 24'h102101);
        repeat (3) tick();
        sample();
        check("ovf_head_stable", rx_data1, 24'h102101);
        tick();
        rx_ready1 = 1'b1;
        repeat (8) tick();
        rx_ready1 = 1'b0;
        sample();
        exp1 = '{24'h102101, 24'h202201, 24'h302301, 24'h402401};
        check("drain_beats", q1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_frame%0d", i), q1[i], exp1[i]);
        end
        check("drain_empty", rx_valid1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
